// File: rtl/sc_point_pkg.sv
// Shared types for the point-rotate controller: FSM state encoding,
// shift codes shared with the rotate register, and the direction update rule.
package sc_point_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_IDLE  = 3'd2,
    S_COUNT = 3'd3,
    S_SHIFT = 3'd4,
    S_PAUSE = 3'd5
  } state_e;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // One button low alone picks a direction; both or neither keep it.
  function automatic logic [1:0] next_dir(
    input logic       left_n,
    input logic       right_n,
    input logic [1:0] dir
  );
    logic [1:0] res;
    res = dir;
    case ({left_n, right_n})
      2'b01:   res = SHIFT_LEFT;
      2'b10:   res = SHIFT_RIGHT;
      default: res = dir;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sc_prescaler_point.sv
// Prescaler counter: synchronous clear, enable, terminal-count compare.
// Ports: clk, rst (async high), clr_i, en_i in; tc_o high once count >= TC_VAL.
module sc_prescaler_point #(
  parameter int               WIDTH  = 25,
  parameter logic [WIDTH-1:0] TC_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o = (count_q >= TC_VAL);

  // Counting stops at the terminal value so a pause taken on the
  // terminal cycle resumes straight into the shift.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sc_statemachine_point.sv
// Control FSM feeding the point-type rotate register: clear, load, then
// periodic shift commands with start/pause/restart and left/right control.
// Inputs: clock, async high reset, active-low buttons.
// Outputs: clear/load strobes (low), shift code, idle flag (low),
// shift pulse and shift counter.
module sc_statemachine_point
  import sc_point_pkg::*;
#(
  parameter int SHIFT_PERIOD     = 25000000,
  parameter int PRESCALER_WIDTH  = 25,
  parameter int SHIFTCOUNT_WIDTH = 8
) (
  input  logic                        SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                        SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                        SC_STATEMACHINEPOINT_start_InLow,
  input  logic                        SC_STATEMACHINEPOINT_pause_InLow,
  input  logic                        SC_STATEMACHINEPOINT_restart_InLow,
  input  logic                        SC_STATEMACHINEPOINT_left_InLow,
  input  logic                        SC_STATEMACHINEPOINT_right_InLow,
  output logic                        SC_STATEMACHINEPOINT_clear_OutLow,
  output logic                        SC_STATEMACHINEPOINT_load0_OutLow,
  output logic [1:0]                  SC_STATEMACHINEPOINT_shiftselection_Out,
  output logic                        SC_STATEMACHINEPOINT_T0_OutLow,
  output logic                        SC_STATEMACHINEPOINT_upcount_out,
  output logic [SHIFTCOUNT_WIDTH-1:0] SC_STATEMACHINEPOINT_shiftcount_OutBUS
);

  // The shift state itself is one cycle of the period.
  localparam logic [PRESCALER_WIDTH-1:0] TC_VAL =
    PRESCALER_WIDTH'(SHIFT_PERIOD - 2);

  logic clk;
  logic rst;
  logic start_n;
  logic pause_n;
  logic restart_n;

  assign clk       = SC_STATEMACHINEPOINT_CLOCK_50;
  assign rst       = SC_STATEMACHINEPOINT_RESET_InHigh;
  assign start_n   = SC_STATEMACHINEPOINT_start_InLow;
  assign pause_n   = SC_STATEMACHINEPOINT_pause_InLow;
  assign restart_n = SC_STATEMACHINEPOINT_restart_InLow;

  state_e                      state_q, state_d;
  logic [1:0]                  dir_q, dir_d;
  logic [SHIFTCOUNT_WIDTH-1:0] shiftcount_q, shiftcount_d;
  logic                        psc_clr;
  logic                        psc_en;
  logic                        psc_tc;

  assign dir_d = next_dir(SC_STATEMACHINEPOINT_left_InLow,
                          SC_STATEMACHINEPOINT_right_InLow,
                          dir_q);

  assign SC_STATEMACHINEPOINT_shiftcount_OutBUS = shiftcount_q;

  sc_prescaler_point #(
    .WIDTH  (PRESCALER_WIDTH),
    .TC_VAL (TC_VAL)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr_i (psc_clr),
    .en_i  (psc_en),
    .tc_o  (psc_tc)
  );

  always_comb begin
    state_d      = state_q;
    shiftcount_d = shiftcount_q;
    psc_clr      = 1'b0;
    psc_en       = 1'b0;
    SC_STATEMACHINEPOINT_clear_OutLow       = 1'b1;
    SC_STATEMACHINEPOINT_load0_OutLow       = 1'b1;
    SC_STATEMACHINEPOINT_shiftselection_Out = SHIFT_HOLD;
    SC_STATEMACHINEPOINT_T0_OutLow          = 1'b1;
    SC_STATEMACHINEPOINT_upcount_out        = 1'b0;
    unique case (state_q)
      S_INIT: begin
        SC_STATEMACHINEPOINT_clear_OutLow = 1'b0;
        psc_clr = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        SC_STATEMACHINEPOINT_load0_OutLow = 1'b0;
        psc_clr = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        SC_STATEMACHINEPOINT_T0_OutLow = 1'b0;
        psc_clr = 1'b1;
        if (!start_n) begin
          state_d      = S_COUNT;
          shiftcount_d = '0;
        end
      end
      S_COUNT: begin
        psc_en = 1'b1;
        if (!restart_n) begin
          state_d = S_INIT;
        end else if (!pause_n) begin
          state_d = S_PAUSE;
        end else if (psc_tc) begin
          state_d = S_SHIFT;
          psc_clr = 1'b1;
        end
      end
      S_SHIFT: begin
        SC_STATEMACHINEPOINT_shiftselection_Out = dir_q;
        SC_STATEMACHINEPOINT_upcount_out        = 1'b1;
        shiftcount_d = shiftcount_q + 1'b1;
        psc_clr      = 1'b1;
        state_d      = restart_n ? S_COUNT : S_INIT;
      end
      S_PAUSE: begin
        if (!restart_n) begin
          state_d = S_INIT;
        end else if (pause_n) begin
          state_d = S_COUNT;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      dir_q        <= SHIFT_LEFT;
      shiftcount_q <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      shiftcount_q <= shiftcount_d;
    end
  end

endmodule

// File: tb/tb_sc_statemachine_point.sv
// Self-checking bench for sc_statemachine_point with SHIFT_PERIOD=4.
// Compares against a countdown-based behavioural model of the run.
module tb_sc_statemachine_point;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_n = 1'b1;
  logic pause_n = 1'b1;
  logic restart_n = 1'b1;
  logic left_n = 1'b1;
  logic right_n = 1'b1;

  logic       clear_n;
  logic       load_n;
  logic [1:0] sel;
  logic       t0_n;
  logic       up;
  logic [7:0] cnt;

  logic [13:0] dut_vec;
  assign dut_vec = {clear_n, load_n, sel, t0_n, up, cnt};

  int errs = 0;
  int checks = 0;

  sc_statemachine_point #(
    .SHIFT_PERIOD     (P),
    .PRESCALER_WIDTH  (3),
    .SHIFTCOUNT_WIDTH (8)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50           (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh       (rst),
    .SC_STATEMACHINEPOINT_start_InLow        (start_n),
    .SC_STATEMACHINEPOINT_pause_InLow        (pause_n),
    .SC_STATEMACHINEPOINT_restart_InLow      (restart_n),
    .SC_STATEMACHINEPOINT_left_InLow         (left_n),
    .SC_STATEMACHINEPOINT_right_InLow        (right_n),
    .SC_STATEMACHINEPOINT_clear_OutLow       (clear_n),
    .SC_STATEMACHINEPOINT_load0_OutLow       (load_n),
    .SC_STATEMACHINEPOINT_shiftselection_Out (sel),
    .SC_STATEMACHINEPOINT_T0_OutLow          (t0_n),
    .SC_STATEMACHINEPOINT_upcount_out        (up),
    .SC_STATEMACHINEPOINT_shiftcount_OutBUS  (cnt)
  );

  always #5 clk = ~clk;

  // Model: "left" is the number of unpaused run cycles still needed
  // before the shift cycle; a pause swallows no more than is owed.
  typedef enum logic [2:0] {
    M_INIT, M_LOAD, M_IDLE, M_RUN, M_PAUSE
  } mmode_t;

  typedef struct packed {
    mmode_t     mode;
    logic       pulse;
    logic [3:0] left;
    logic [1:0] dir;
    logic [7:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic st_n, logic ps_n,
                                  logic rs_n, logic l_n, logic r_n);
    model_t n;
    n = s;
    if (!l_n && r_n) n.dir = 2'b01;
    if (l_n && !r_n) n.dir = 2'b10;
    case (s.mode)
      M_INIT: n.mode = M_LOAD;
      M_LOAD: n.mode = M_IDLE;
      M_IDLE: if (!st_n) begin
        n.mode = M_RUN;
        n.left = 4'(P - 1);
        n.cnt = 8'd0;
        n.pulse = 1'b0;
      end
      M_RUN: begin
        if (s.pulse) begin
          n.cnt = s.cnt + 8'd1;
          n.pulse = 1'b0;
          n.left = 4'(P - 1);
          if (!rs_n) n.mode = M_INIT;
        end else if (!rs_n) begin
          n.mode = M_INIT;
        end else if (!ps_n) begin
          n.mode = M_PAUSE;
          if (s.left > 4'd1) n.left = s.left - 4'd1;
        end else if (s.left == 4'd1) begin
          n.pulse = 1'b1;
        end else begin
          n.left = s.left - 4'd1;
        end
      end
      M_PAUSE: begin
        if (!rs_n) n.mode = M_INIT;
        else if (ps_n) n.mode = M_RUN;
      end
      default: n.mode = M_INIT;
    endcase
    return n;
  endfunction

  function automatic logic [13:0] exp_vec(model_t s);
    return {s.mode != M_INIT, s.mode != M_LOAD,
            s.pulse ? s.dir : 2'b00, s.mode != M_IDLE,
            s.pulse, s.cnt};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{mode: M_INIT, pulse: 1'b0, left: 4'd0,
             dir: 2'b01, cnt: 8'd0};
    end else begin
      m <= step(m, start_n, pause_n, restart_n, left_n, right_n);
    end
  end

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (up === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (clear_n !== 1'b0 || up !== 1'b0) begin
      errs++;
      $display("FAIL reset_clear got clr=%b up=%b exp clr=0 up=0",
               clear_n, up);
    end
    checks++;
    if (dut_vec !== exp_vec(m)) begin
      errs++;
      $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec(m));
    end
    checks++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (clear_n !== 1'b0) begin
      errs++;
      $display("FAIL rel_init got clr=%b exp 0", clear_n);
    end
    checks++;
    @(negedge clk);
    if (load_n !== 1'b0 || clear_n !== 1'b1) begin
      errs++;
      $display("FAIL init_load got ld=%b clr=%b exp ld=0 clr=1",
               load_n, clear_n);
    end
    checks++;
    @(negedge clk);
    if (t0_n !== 1'b0 || load_n !== 1'b1) begin
      errs++;
      $display("FAIL init_idle got t0=%b ld=%b exp t0=0 ld=1",
               t0_n, load_n);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (t0_n !== 1'b0 || up !== 1'b0) begin
        errs++;
        $display("FAIL idle_hold got t0=%b up=%b exp t0=0 up=0", t0_n, up);
      end
      checks++;
      if (dut_vec !== exp_vec(m)) begin
        errs++;
        $display("FAIL idle_vec got=%h exp=%h", dut_vec, exp_vec(m));
      end
      checks++;
    end
  endtask

  task automatic test_start;
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      if (up !== ((j % P) == 0)) begin
        errs++;
        $display("FAIL start_up j=%0d got=%b exp=%b", j, up, (j % P) == 0);
      end
      checks++;
      if ((j % P) == 0 && sel !== 2'b01) begin
        errs++;
        $display("FAIL start_sel j=%0d got=%b exp=01", j, sel);
      end
      if ((j % P) == 0) checks++;
      if ((j % P) == 1 && j > 1 && cnt !== 8'((j - 1) / P)) begin
        errs++;
        $display("FAIL start_cnt j=%0d got=%0d exp=%0d", j, cnt, (j - 1) / P);
      end
      if ((j % P) == 1 && j > 1) checks++;
      if (dut_vec !== exp_vec(m)) begin
        errs++;
        $display("FAIL start_vec j=%0d got=%h exp=%h", j, dut_vec, exp_vec(m));
      end
      checks++;
      if (j < 13) @(negedge clk);
    end
  endtask

  task automatic test_direction;
    bit ok;
    right_n = 1'b0;
    @(negedge clk);
    right_n = 1'b1;
    wait_pulse(ok);
    if (!ok || sel !== 2'b10) begin
      errs++;
      $display("FAIL dir_right ok=%b got=%b exp=10", ok, sel);
    end
    checks++;
    @(negedge clk);
    left_n = 1'b0;
    right_n = 1'b0;
    @(negedge clk);
    left_n = 1'b1;
    right_n = 1'b1;
    wait_pulse(ok);
    if (!ok || sel !== 2'b10) begin
      errs++;
      $display("FAIL dir_both ok=%b got=%b exp=10", ok, sel);
    end
    checks++;
    left_n = 1'b0;
    #1;
    if (sel !== 2'b10) begin
      errs++;
      $display("FAIL dir_same_cycle got=%b exp=10", sel);
    end
    checks++;
    @(negedge clk);
    left_n = 1'b1;
    wait_pulse(ok);
    if (!ok || sel !== 2'b01) begin
      errs++;
      $display("FAIL dir_left ok=%b got=%b exp=01", ok, sel);
    end
    checks++;
    if (dut_vec !== exp_vec(m)) begin
      errs++;
      $display("FAIL dir_vec got=%h exp=%h", dut_vec, exp_vec(m));
    end
    checks++;
  endtask

  task automatic test_pause;
    bit ok;
    int n;
    wait_pulse(ok);
    if (!ok) begin
      errs++;
      $display("FAIL pause_sync got no pulse exp pulse");
    end
    checks++;
    @(negedge clk);
    @(negedge clk);
    pause_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (up !== 1'b0) begin
        errs++;
        $display("FAIL pause_up i=%0d got=%b exp=0", i, up);
      end
      checks++;
      if (dut_vec !== exp_vec(m)) begin
        errs++;
        $display("FAIL pause_vec got=%h exp=%h", dut_vec, exp_vec(m));
      end
      checks++;
    end
    pause_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (up === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n != 2) begin
      errs++;
      $display("FAIL pause_resume got=%0d cycles exp=2", n);
    end
    checks++;
    if (dut_vec !== exp_vec(m)) begin
      errs++;
      $display("FAIL resume_vec got=%h exp=%h", dut_vec, exp_vec(m));
    end
    checks++;
  endtask

  task automatic test_wrap_restart;
    bit hit;
    bit ok;
    hit = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (dut_vec !== exp_vec(m)) begin
        errs++;
        $display("FAIL wrap_vec got=%h exp=%h", dut_vec, exp_vec(m));
      end
      checks++;
      if (m.pulse && m.cnt == 8'hff) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      errs++;
      $display("FAIL wrap_reach got no 255 shift exp one");
    end
    checks++;
    @(negedge clk);
    if (cnt !== 8'h00) begin
      errs++;
      $display("FAIL wrap got=%0d exp=0", cnt);
    end
    checks++;
    wait_pulse(ok);
    @(negedge clk);
    if (!ok || cnt !== 8'h01) begin
      errs++;
      $display("FAIL after_wrap ok=%b got=%0d exp=1", ok, cnt);
    end
    checks++;
    pause_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    restart_n = 1'b0;
    @(negedge clk);
    restart_n = 1'b1;
    pause_n = 1'b1;
    if (clear_n !== 1'b0 || cnt !== 8'h01) begin
      errs++;
      $display("FAIL restart_init got clr=%b cnt=%0d exp clr=0 cnt=1",
               clear_n, cnt);
    end
    checks++;
    @(negedge clk);
    if (load_n !== 1'b0) begin
      errs++;
      $display("FAIL restart_load got=%b exp=0", load_n);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (t0_n !== 1'b0 || cnt !== 8'h01 || up !== 1'b0) begin
        errs++;
        $display("FAIL restart_idle got t0=%b cnt=%0d up=%b exp 0/1/0",
                 t0_n, cnt, up);
      end
      checks++;
    end
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    if (cnt !== 8'h00 || t0_n !== 1'b1) begin
      errs++;
      $display("FAIL restart_start got cnt=%0d t0=%b exp 0/1", cnt, t0_n);
    end
    checks++;
  endtask

  task automatic test_async_reset;
    bit ok;
    right_n = 1'b0;
    @(negedge clk);
    right_n = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    if (clear_n !== 1'b0 || up !== 1'b0 || cnt !== 8'h00) begin
      errs++;
      $display("FAIL async_rst got clr=%b up=%b cnt=%0d exp 0/0/0",
               clear_n, up, cnt);
    end
    checks++;
    if (dut_vec !== exp_vec(m)) begin
      errs++;
      $display("FAIL async_vec got=%h exp=%h", dut_vec, exp_vec(m));
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (load_n !== 1'b0) begin
      errs++;
      $display("FAIL async_load got=%b exp=0", load_n);
    end
    checks++;
    @(negedge clk);
    if (t0_n !== 1'b0) begin
      errs++;
      $display("FAIL async_idle got=%b exp=0", t0_n);
    end
    checks++;
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    wait_pulse(ok);
    if (!ok || sel !== 2'b01) begin
      errs++;
      $display("FAIL async_dir ok=%b got=%b exp=01", ok, sel);
    end
    checks++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      start_n   = ($urandom_range(0, 7) != 0);
      pause_n   = ($urandom_range(0, 5) != 0);
      restart_n = ($urandom_range(0, 49) != 0);
      left_n    = ($urandom_range(0, 9) != 0);
      right_n   = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      if (dut_vec !== exp_vec(m)) begin
        errs++;
        $display("FAIL rand_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec(m));
      end
      checks++;
    end
    start_n = 1'b1;
    pause_n = 1'b1;
    restart_n = 1'b1;
    left_n = 1'b1;
    right_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_direction();
    test_pause();
    test_wrap_restart();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_point.md
Name: sc_statemachine_point

Overview:
- Control FSM directly upstream of the point-type rotate register.
- Sequences clear, initial load and periodic rotate commands, with direction, pause and restart control from debounced active-low buttons.
- Drives the register's clear_InLow, load1_InLow and shiftselection_In inputs.
- Also produces the T0_InLow idle flag and upcount_out shift-pulse signals that the register-side logic consumes.

Parameters:
- SHIFT_PERIOD, 25000000: clock cycles between consecutive shift commands; must be >= 2.
- PRESCALER_WIDTH, 25: prescaler counter width; must satisfy 2^PRESCALER_WIDTH > SHIFT_PERIOD.
- SHIFTCOUNT_WIDTH, 8: width of the shift counter.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, single clock domain.
- SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_STATEMACHINEPOINT_start_InLow  in  1  start the run from idle.
- SC_STATEMACHINEPOINT_pause_InLow  in  1  level; 0 holds the run.
- SC_STATEMACHINEPOINT_restart_InLow  in  1  return to the init sequence.
- SC_STATEMACHINEPOINT_left_InLow  in  1  select rotate-left direction.
- SC_STATEMACHINEPOINT_right_InLow  in  1  select rotate-right direction.
- SC_STATEMACHINEPOINT_clear_OutLow  out  1  to register clear_InLow.
- SC_STATEMACHINEPOINT_load0_OutLow  out  1  to register load1_InLow.
- SC_STATEMACHINEPOINT_shiftselection_Out  out  2  to register shiftselection_In.
- SC_STATEMACHINEPOINT_T0_OutLow  out  1  0 while idle waiting for start.
- SC_STATEMACHINEPOINT_upcount_out  out  1  one-cycle pulse per shift.
- SC_STATEMACHINEPOINT_shiftcount_OutBUS  out  SHIFTCOUNT_WIDTH  shifts since start.

Behaviour:
- States and transitions; outputs are Moore-decoded from the state register:
  - S_INIT: clear_OutLow=0; next state S_LOAD.
  - S_LOAD: load0_OutLow=0; next state S_IDLE.
  - S_IDLE: T0_OutLow=0. On start_InLow==0, go to S_COUNT; prescaler=0, shiftcount=0.
  - S_COUNT: prescaler increments each cycle. Priority order:
    - restart_InLow==0 -> S_INIT.
    - else pause_InLow==0 -> S_PAUSE.
    - else prescaler==SHIFT_PERIOD-2 -> S_SHIFT, prescaler=0.
  - S_SHIFT: shiftselection_Out=dir, upcount_out=1, shiftcount increments. Next state S_COUNT, or S_INIT if restart is asserted.
  - S_PAUSE: prescaler held. restart_InLow==0 -> S_INIT; else pause_InLow==1 -> S_COUNT, resuming from the held prescaler value.
- Default output values in every state not listed above: clear=1, load0=1, shiftselection=2'b00, T0=1, upcount=0.
- Timing:
  - Start sampled at edge k; first shift pulse occurs in cycle k+SHIFT_PERIOD.
  - Subsequent shift pulses are exactly SHIFT_PERIOD cycles apart while unpaused.
- Direction register dir:
  - Reset value 2'b01 (left).
  - left_InLow==0 alone -> 2'b01. right_InLow==0 alone -> 2'b10. Both low or both high -> unchanged.
  - Updates in every state.
  - Registered: a press in the same cycle as S_SHIFT affects the next shift, not the current one.
- shiftcount wraps from 2^SHIFTCOUNT_WIDTH-1 to 0 without a flag. It is cleared on S_IDLE->S_COUNT and held in all other states.
- Reset (asynchronous, any time, including mid-run or mid-pause):
  - state=S_INIT, prescaler=0, shiftcount=0, dir=2'b01.
  - Outputs during and immediately after reset: clear_OutLow=0, others at default values.
- After reset release: S_INIT 1 cycle, then S_LOAD 1 cycle, then S_IDLE.
- start_InLow is ignored outside S_IDLE. pause_InLow is ignored in S_INIT, S_LOAD and S_IDLE.
- The shiftselection code 2'b11 is never driven.

Decomposition:
- Shared package sc_point_pkg holds:
  - State encodings (3-bit): S_INIT=0, S_LOAD=1, S_IDLE=2, S_COUNT=3, S_SHIFT=4, S_PAUSE=5.
  - Shift codes: SHIFT_HOLD=2'b00, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10. These are shared with the rotate register.
- One sub-module, sc_prescaler_point: counter with synchronous clear, enable and terminal-count compare output.

Test Plan (all scenarios use SHIFT_PERIOD=4):
1. Reset released, no buttons pressed -> clear=0 for 1 cycle, then load0=0 for 1 cycle, then T0=0 steady; upcount stays 0.
2. start pulse at edge k, buttons idle -> upcount pulses in cycles k+4, k+8, k+12 with shiftselection=01 in those cycles only; shiftcount reads 1, 2, 3.
3. right_InLow pulse during S_COUNT -> next shift has shiftselection=10. Both left and right low together -> direction unchanged.
4. pause low for 10 cycles starting two cycles after a shift -> no upcount while paused; after release, the next pulse arrives after only the remaining count cycles (2 cycles instead of 4).
5. shiftcount at 255, one more shift -> shiftcount=0. Restart during S_PAUSE -> clear, load, idle sequence; shiftcount holds until the next start.
6. Asynchronous reset asserted mid-S_COUNT, between clock edges -> clear_OutLow=0 immediately and dir=01; after release, the init sequence is repeated.
